// File: rtl/time_keeper.sv
// Time-of-day source: divides clk down to a 1 Hz tick and keeps hh:mm:ss, with a button-driven set mode.
// Optional 12-hour display counting with PM flag is enabled by defining TIME_KEEPER_12H_EN.
module time_keeper #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        setting_enable,
  input  logic        set_hr_or_min,
  input  logic        inc_short,
  output logic [13:0] hour,
  output logic [13:0] minute,
  output logic [13:0] second,
  output logic        pm,
  output logic        sec_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

`ifdef TIME_KEEPER_12H_EN
  localparam logic [4:0] HOUR_RESET = 5'd12;
`else
  localparam logic [4:0] HOUR_RESET = 5'd0;
`endif

  logic [PW-1:0] r_presc;
  logic          r_secTick;
  logic [4:0]    r_hour;
  logic [5:0]    r_minute;
  logic [5:0]    r_second;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_incPrev;

  logic          w_prescDone;
  logic          w_incEvent;
  logic          w_secWrap;
  logic          w_minWrap;
  logic [5:0]    w_secondNext;
  logic [5:0]    w_minuteNext;
  logic [4:0]    w_hourNext;

  assign w_prescDone  = (r_presc == PRESC_LAST);
  assign w_incEvent   = r_sync2 & ~r_incPrev;
  assign w_secWrap    = (r_second == 6'd59);
  assign w_minWrap    = (r_minute == 6'd59);
  assign w_secondNext = w_secWrap ? 6'd0 : r_second + 6'd1;
  assign w_minuteNext = w_minWrap ? 6'd0 : r_minute + 6'd1;

`ifdef TIME_KEEPER_12H_EN
  logic r_pm;
  logic w_pmNext;

  // 12-hour face shows 12,1..11; pm flips when 11 rolls into 12
  assign w_hourNext = (r_hour == 5'd12) ? 5'd1 : r_hour + 5'd1;
  assign w_pmNext   = (r_hour == 5'd11) ? ~r_pm : r_pm;
  assign pm         = r_pm;
`else
  assign w_hourNext = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
  assign pm         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_incPrev <= 1'b0;
    end else begin
      r_sync1   <= inc_short;
      r_sync2   <= r_sync1;
      r_incPrev <= r_sync2;
    end
  end

  // Set mode is checked first, so a tick coinciding with entry into set mode is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_secTick <= 1'b0;
      r_hour    <= HOUR_RESET;
      r_minute  <= 6'd0;
      r_second  <= 6'd0;
`ifdef TIME_KEEPER_12H_EN
      r_pm      <= 1'b0;
`endif
    end else if (setting_enable) begin
      r_presc   <= '0;
      r_secTick <= 1'b0;
      r_second  <= 6'd0;
      if (w_incEvent) begin
        if (set_hr_or_min) begin
          r_minute <= w_minuteNext;
        end else begin
          r_hour <= w_hourNext;
`ifdef TIME_KEEPER_12H_EN
          r_pm   <= w_pmNext;
`endif
        end
      end
    end else if (w_prescDone) begin
      r_presc   <= '0;
      r_secTick <= 1'b1;
      r_second  <= w_secondNext;
      if (w_secWrap) begin
        r_minute <= w_minuteNext;
        if (w_minWrap) begin
          r_hour <= w_hourNext;
`ifdef TIME_KEEPER_12H_EN
          r_pm   <= w_pmNext;
`endif
        end
      end
    end else begin
      r_presc   <= r_presc + PW'(1);
      r_secTick <= 1'b0;
    end
  end

  assign hour     = {9'd0, r_hour};
  assign minute   = {8'd0, r_minute};
  assign second   = {8'd0, r_second};
  assign sec_tick = r_secTick;

endmodule

// File: doc/time_keeper.md
# time_keeper

Free-running time-of-day source for the digital clock. It divides the board clock down to a 1 Hz tick and maintains seconds, minutes and hours. Its hour/minute outputs drive the alarm comparator and the display path. It also implements the front-panel set mode, in which a short-press button increments hours or minutes.

## Interface
- `CLK_HZ`, default 50_000_000: clk cycles per second; prescaler terminal count is `CLK_HZ-1`. Benches use small values, e.g. 4.
- `clk` input 1: system clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `setting_enable` input 1: 1 = set mode (time frozen, button edits enabled). Synchronous level, already registered upstream.
- `set_hr_or_min` input 1: field select in set mode; 0 = hour, 1 = minute. Synchronous level.
- `inc_short` input 1: raw button. Asynchronous to `clk`; synchronized internally.
- `hour` output 14: current hour, 0..23 (1..12 with `TIME_KEEPER_12H_EN`); bits 13:5 always 0.
- `minute` output 14: 0..59; bits 13:6 always 0.
- `second` output 14: 0..59; bits 13:6 always 0.
- `pm` output 1: PM flag; constant 0 without `TIME_KEEPER_12H_EN`.
- `sec_tick` output 1: one-cycle pulse each elapsed second in run mode.

## Operation
- **Prescaler**
  - Counter 0..CLK_HZ-1, counting in run mode.
  - At terminal count it wraps to 0 and asserts `sec_tick` for one cycle, registered.
- **Run mode** (`setting_enable`=0), on each tick:
  - `second` increments.
  - `second` 59→0 carries `minute`+1.
  - `minute` 59→0 carries `hour`+1.
  - `hour` 23→0.
  - All carries resolve in the same cycle, so 23:59:59 → 00:00:00 atomically.
- **Set mode** (`setting_enable`=1):
  - Prescaler held at 0, `second` forced to 0, `sec_tick` held 0.
  - Each accepted increment event adds 1 to the selected field.
  - Hour wraps 23→0; minute wraps 59→0.
  - No carry between fields; `second` is untouched beyond being held at 0.
- **Increment event**
  - `inc_short` passes through a 2-flop synchronizer, then a rising-edge detect against a third register.
  - One event per low→high transition; a held button gives exactly one increment.
  - Events while `setting_enable`=0 are discarded, not queued.
- **Field select**: `set_hr_or_min` is sampled in the same cycle the event is applied.
- **Simultaneous events**: if `setting_enable` rises in the cycle a tick would fire, set mode wins and the tick is dropped.
- **Reset**: asynchronous. It clears prescaler, synchronizer and edge registers, and all outputs, at any point including mid-carry.

## Timing
- Reset values:
  - `hour`=0, `minute`=0, `second`=0, `pm`=0, `sec_tick`=0.
  - With `TIME_KEEPER_12H_EN`: `hour`=12, `pm`=0.
- Tick period is exactly CLK_HZ cycles.
- After `rst` deassert or a `setting_enable` 1→0 transition, the first `sec_tick` is CLK_HZ cycles later.
- `second`/`minute`/`hour` update on the same edge that asserts `sec_tick`.
- Increment latency: if `inc_short` rises before edge N, the field updates on edge N+2. That is 3 edges inclusive; the output is stable after edge N+2.
- Minimum button high/low time: 2 clk cycles for guaranteed detection.

## Configuration
- Macro: `TIME_KEEPER_12H_EN`.
- **Defined**:
  - `hour` counts 12,1..11, with `pm` toggling on the 11→12 transition.
  - Run mode: 11:59:59 → 12:00:00 toggles `pm`.
  - Set mode: hour increment 12→1 leaves `pm` unchanged; 11→12 toggles `pm`.
- **Undefined**: 24-hour counting as above, and `pm` tied to 0.
- The alarm block compares 24-hour values, so production builds leave the macro undefined.

## Test plan
- **Reset and counting**, CLK_HZ=4, release `rst`:
  - all outputs 0;
  - first `sec_tick` 4 cycles later, `second`=1;
  - after 240 cycles `minute`=1, `second`=0.
- **Midnight rollover**:
  - set 23:59 via set mode, exit, run 59 ticks to `second`=59;
  - the next tick gives `hour`=0, `minute`=0, `second`=0 on one edge.
- **Hour wrap in set mode**: `setting_enable`=1, `set_hr_or_min`=0, 24 button pulses from `hour`=0 → `hour`=0, `minute` unchanged, `sec_tick` never asserted.
- **Minute wrap**: `set_hr_or_min`=1, `minute`=59, one pulse → `minute`=0, `hour` unchanged.
- **Button filtering**:
  - `inc_short` held high 20 cycles → exactly +1, 3 edges after the rise;
  - 3 pulses with `setting_enable`=0 → no change.
- **Reset mid-operation**: assert `rst` asynchronously at 05:17:42 mid-prescaler → all outputs 0 immediately; the next `sec_tick` comes CLK_HZ cycles after deassert.
